fifo_sync_ctl: RTL
==================

Name: fifo_sync_ctl

Overview:
Parametrised single-clock FIFO, next generation of the team's synchronous FIFO. Adds:
- selectable standard or first-word-fall-through (FWFT) read mode
- programmable almost-full and almost-empty flags
- sticky overflow and underflow error flags with clear
- synchronous flush
- read-valid strobe

Sits between producer and consumer stages in the same clock domain; capacity is DEPTH words in both modes.

Parameters:
WIDTH, 8, bits per word (>=1)
DEPTH, 16, capacity in words; power of two, >=4
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through
AFULL_LVL, 14, almost_full asserted when used >= AFULL_LVL; legal 1..DEPTH
AEMPTY_LVL, 2, almost_empty asserted when used <= AEMPTY_LVL; legal 0..DEPTH-1

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, asynchronous assert, active-low
flush  in  1  synchronous clear of contents
clr_err  in  1  synchronous clear of overflow/underflow
wr_en  in  1  write request
wr_data  in  WIDTH  write data
full  out  1  used == DEPTH
almost_full  out  1  used >= AFULL_LVL
overflow  out  1  sticky: write attempted while full
rd_en  in  1  read request (FWFT: acknowledge/pop of head)
rd_data  out  WIDTH  read data
rd_valid  out  1  standard: 1-cycle pulse, rd_data holds word just read; FWFT: equals !empty
empty  out  1  used == 0
almost_empty  out  1  used <= AEMPTY_LVL
underflow  out  1  sticky: read attempted while empty
used  out  $clog2(DEPTH)+1  stored word count, 0..DEPTH

Behaviour:
- Reset (rst_n low, async, any time including mid-transfer):
  - pointers and used = 0; rd_data = 0; rd_valid = 0
  - full = 0; empty = 1; almost_empty = 1; almost_full = 0
  - overflow = 0; underflow = 0
  - contents discarded
- Write accepted iff wr_en && !full && !flush. Read accepted iff rd_en && !empty && !flush. full/empty use registered state only; no read-during-full pass-through.
- Priority per cycle: reset > flush > accepted read/write.
- flush:
  - next cycle: used = 0, empty = 1, full = 0, rd_valid = 0, rd_data = 0
  - wr_en and rd_en that cycle are ignored and do not set overflow or underflow
  - sticky flags are unchanged
- used update: +1 write only, -1 read only, unchanged for both or neither. Never wraps past 0 or DEPTH.
- All outputs are functions of registered state; no combinational path from any input to any output.
- Standard mode (FWFT=0):
  - Accepted read at edge N: rd_data = head word and rd_valid = 1 after edge N; rd_valid = 0 after N+1 unless another read.
  - rd_data holds its value otherwise.
  - Write into empty FIFO at edge N: empty = 0 after edge N.
- FWFT mode (FWFT=1):
  - Head word is presented on rd_data whenever empty = 0.
  - Write into empty FIFO at edge N: rd_data = that word and empty = 0 after edge N (1-cycle write-to-visible latency).
  - Accepted rd_en at edge N pops the head; rd_data shows the next word after edge N, or empty = 1 if none.
  - Simultaneous write and read at used==1: old head popped, new word visible next cycle, used stays 1, empty stays 0.
  - rd_data content when empty = 1 is don't-care.
- Simultaneous write and read, 0 < used < DEPTH: both occur, used unchanged.
- Full, wr_en && rd_en: read only, used -> DEPTH-1, overflow set. Empty, wr_en && rd_en: write only, underflow set.
- Sticky flags:
  - overflow set on wr_en && full && !flush; underflow set on rd_en && empty && !flush
  - both cleared by clr_err; set has priority over clr_err in the same cycle
- Pointers carry a wrap bit; index = low $clog2(DEPTH) bits. Wrap-around is seamless and preserves data order indefinitely.
- Illegal parameter values are an elaboration-time error.

Test Plan:
- Defaults, FWFT=0: write 0x01..0x10 back-to-back -> full=1 after 16th edge, almost_full=1 from used=14; then 16 reads return 0x01..0x10 in order, each with a 1-cycle rd_valid pulse, empty=1 at end.
- FWFT=1: single write 0xA5 into empty FIFO -> next cycle empty=0, rd_data=0xA5 with no rd_en; rd_en one cycle -> empty=1, used=0.
- Full plus wr_en=1, rd_en=1 -> used=15, overflow=1, dropped word never read. Empty plus rd_en -> underflow=1, used=0. clr_err -> both 0 next cycle.
- used=8, assert flush with wr_en and rd_en -> used=0, empty=1, no flags set; next write of 0x3C is read back first.
- 1000 cycles random wr_en/rd_en at 50%, both modes, against a scoreboard -> order preserved across multiple pointer wraps; used, almost_full and almost_empty match the model every cycle.
- Drop rst_n asynchronously mid-burst at used=5 -> outputs reach reset values before the next clock edge; operation resumes correctly after release.

Source files
------------

// File: rtl/fifo_sync_ctl.sv
// fifo_sync_ctl: single-clock FIFO with standard/FWFT read, almost flags, sticky errors and flush
module fifo_sync_ctl #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int FWFT       = 0,
  parameter int AFULL_LVL  = 14,
  parameter int AEMPTY_LVL = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       clr_err,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  output logic                       full,
  output logic                       almost_full,
  output logic                       overflow,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_valid,
  output logic                       empty,
  output logic                       almost_empty,
  output logic                       underflow,
  output logic [$clog2(DEPTH):0]     used
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_CNT = (AW+1)'(AFULL_LVL);
  localparam logic [AW:0] AE_CNT = (AW+1)'(AEMPTY_LVL);
  if (WIDTH < 1 || DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || (FWFT != 0 && FWFT != 1) ||
      AFULL_LVL < 1 || AFULL_LVL > DEPTH || AEMPTY_LVL < 0 || AEMPTY_LVL > DEPTH - 1) begin : g_bad_param
    $error("fifo_sync_ctl: illegal parameter value");
  end
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic rd_valid_q, rd_valid_d, overflow_q, overflow_d, underflow_q, underflow_d;
  logic wr_acc, rd_acc;
  // Pointers carry a wrap bit, so their difference is the exact count 0..DEPTH.
  assign used         = wr_ptr_q - rd_ptr_q;
  assign full         = used == FULL_CNT;
  assign empty        = used == '0;
  assign almost_full  = used >= AF_CNT;
  assign almost_empty = used <= AE_CNT;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  // FWFT presents the head straight from storage; zero when empty keeps reset/flush at 0.
  assign rd_data      = (FWFT != 0) ? (empty ? '0 : mem_q[rd_ptr_q[AW-1:0]]) : rd_data_q;
  assign rd_valid     = (FWFT != 0) ? !empty : rd_valid_q;
  always_comb begin
    wr_acc      = wr_en && !full && !flush;
    rd_acc      = rd_en && !empty && !flush;
    wr_ptr_d    = flush ? '0 : wr_ptr_q + (AW+1)'(wr_acc);
    rd_ptr_d    = flush ? '0 : rd_ptr_q + (AW+1)'(rd_acc);
    rd_data_d   = flush ? '0 : rd_acc ? mem_q[rd_ptr_q[AW-1:0]] : rd_data_q;
    rd_valid_d  = rd_acc;
    overflow_d  = (wr_en && full && !flush) || (overflow_q && !clr_err);
    underflow_d = (rd_en && empty && !flush) || (underflow_q && !clr_err);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end
endmodule
